// File: rtl/hoeraa_err_sweep.sv
// hoeraa_err_sweep: error-characterisation controller for the 8-bit HOERAA
// approximate adder. It sweeps a rectangle of operand pairs (A outer, B inner)
// through a HOERAA instance and an exact adder, one pair per cycle. A 3-stage
// pipeline feeds the error metric accumulators.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   start                request a sweep (accepted only when idle)
//   abort                cancel a running sweep; metrics keep partial values
//   stall                freeze sweep, pipeline and accumulators this cycle
//   a_lo/a_hi, b_lo/b_hi inclusive operand bounds (A outer, B inner)
//   busy                 sweep in progress
//   done                 one-cycle pulse when metrics are final
//   bad_range            raised with done when a bound pair is inverted
//   pair_cnt, err_cnt    pairs evaluated / pairs with a nonzero error
//   sed, max_ed          saturating sum and maximum of |approx - exact|
module hoeraa_err_sweep #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             stall,
  input  logic [7:0]       a_lo,
  input  logic [7:0]       a_hi,
  input  logic [7:0]       b_lo,
  input  logic [7:0]       b_hi,
  output logic             busy,
  output logic             done,
  output logic             bad_range,
  output logic [16:0]      pair_cnt,
  output logic [16:0]      err_cnt,
  output logic [ACC_W-1:0] sed,
  output logic [8:0]       max_ed
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t           state_r;
  logic [7:0]       a_hi_r, b_lo_r, b_hi_r;
  logic [7:0]       a_cnt_r, b_cnt_r;
  logic             s0_v_r, s1_v_r;
  logic [7:0]       s0_a_r, s0_b_r;
  logic [8:0]       s1_apx_r, s1_ext_r;
  logic [8:0]       ed_s;
  logic [ACC_W:0]   sed_sum_s;
  logic [ACC_W-1:0] sed_next_s;
  logic             bad_s, last_b_s, last_pair_s;

  // HOERAA: low two bits forced high, bits 3:2 OR-ed, and the upper nibble
  // adds exactly, with a carry-in guessed from a[3] & b[3].
  function automatic logic [8:0] hoeraa_add(input logic [7:0] a, input logic [7:0] b);
    logic [4:0] hi;
    hi = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0000, a[3] & b[3]};
    return {hi, a[3:2] | b[3:2], 2'b11};
  endfunction

  // Error distance, saturating SED update and sweep terminal flags
  always_comb begin
    ed_s        = 9'd0;
    sed_next_s  = sed;
    if (s1_apx_r >= s1_ext_r) begin
      ed_s = s1_apx_r - s1_ext_r;
    end else begin
      ed_s = s1_ext_r - s1_apx_r;
    end
    sed_sum_s = {1'b0, sed} + {{(ACC_W-8){1'b0}}, ed_s};
    if (sed_sum_s[ACC_W]) begin
      sed_next_s = {ACC_W{1'b1}};
    end else begin
      sed_next_s = sed_sum_s[ACC_W-1:0];
    end
    bad_s       = (a_lo > a_hi) || (b_lo > b_hi);
    // Terminal detection by equality so bounds of 255 never rely on wrap.
    last_b_s    = (b_cnt_r == b_hi_r);
    last_pair_s = last_b_s && (a_cnt_r == a_hi_r);
  end

  // Pipeline datapath: S0 operands, S1 approximate and exact sums
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_a_r   <= 8'd0;
      s0_b_r   <= 8'd0;
      s1_apx_r <= 9'd0;
      s1_ext_r <= 9'd0;
    end else if (!stall) begin
      s0_a_r   <= a_cnt_r;
      s0_b_r   <= b_cnt_r;
      s1_apx_r <= hoeraa_add(s0_a_r, s0_b_r);
      s1_ext_r <= {1'b0, s0_a_r} + {1'b0, s0_b_r};
    end
  end

  // Sweep FSM, operand counters, pipeline valids and metric accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      a_hi_r    <= 8'd0;
      b_lo_r    <= 8'd0;
      b_hi_r    <= 8'd0;
      a_cnt_r   <= 8'd0;
      b_cnt_r   <= 8'd0;
      s0_v_r    <= 1'b0;
      s1_v_r    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bad_range <= 1'b0;
      pair_cnt  <= 17'd0;
      err_cnt   <= 17'd0;
      sed       <= {ACC_W{1'b0}};
      max_ed    <= 9'd0;
    end else begin
      done <= 1'b0;
      if ((state_r != IDLE) && abort) begin
        // Abort beats stall; the pair in S1 is dropped and metrics hold.
        state_r <= IDLE;
        busy    <= 1'b0;
        s0_v_r  <= 1'b0;
        s1_v_r  <= 1'b0;
      end else if (!stall) begin
        s1_v_r <= s0_v_r;
        if (s1_v_r) begin
          pair_cnt <= pair_cnt + 17'd1;
          err_cnt  <= err_cnt + {16'd0, (ed_s != 9'd0)};
          sed      <= sed_next_s;
          if (ed_s > max_ed) begin
            max_ed <= ed_s;
          end
        end
        case (state_r)
          IDLE: begin
            s0_v_r <= 1'b0;
            if (start) begin
              pair_cnt <= 17'd0;
              err_cnt  <= 17'd0;
              sed      <= {ACC_W{1'b0}};
              max_ed   <= 9'd0;
              if (bad_s) begin
                done      <= 1'b1;
                bad_range <= 1'b1;
              end else begin
                bad_range <= 1'b0;
                a_hi_r    <= a_hi;
                b_lo_r    <= b_lo;
                b_hi_r    <= b_hi;
                a_cnt_r   <= a_lo;
                b_cnt_r   <= b_lo;
                busy      <= 1'b1;
                state_r   <= RUN;
              end
            end
          end
          RUN: begin
            s0_v_r <= 1'b1;
            if (last_pair_s) begin
              state_r <= DRAIN;
            end else if (last_b_s) begin
              b_cnt_r <= b_lo_r;
              a_cnt_r <= a_cnt_r + 8'd1;
            end else begin
              b_cnt_r <= b_cnt_r + 8'd1;
            end
          end
          DRAIN: begin
            s0_v_r <= 1'b0;
            if (!s0_v_r && !s1_v_r) begin
              state_r <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
          default: begin
            state_r <= IDLE;
            busy    <= 1'b0;
            s0_v_r  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hoeraa_err_sweep.sv
// Self-checking bench for hoeraa_err_sweep. A behavioural model computes the
// expected metrics and done/busy timing of each sweep from the arithmetic
// definition of HOERAA. One compare process checks the DUT against it on
// every falling edge.
module tb_hoeraa_err_sweep;
  localparam int ACC_W = 32;
  localparam int BIG   = 1 << 30;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             stall = 1'b0;
  logic [7:0]       a_lo = 8'd0, a_hi = 8'd0, b_lo = 8'd0, b_hi = 8'd0;
  logic             busy, done, bad_range;
  logic [16:0]      pair_cnt, err_cnt;
  logic [ACC_W-1:0] sed;
  logic [8:0]       max_ed;

  hoeraa_err_sweep #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
    .a_lo(a_lo), .a_hi(a_hi), .b_lo(b_lo), .b_hi(b_hi),
    .busy(busy), .done(done), .bad_range(bad_range),
    .pair_cnt(pair_cnt), .err_cnt(err_cnt), .sed(sed), .max_ed(max_ed)
  );

  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // mode: 0 none, 1 good sweep, 2 bad range, 3 aborted sweep
  int     mode = 0, s_edge = 0, d_edge = 0;
  int     e_pairs = 0, e_err = 0, e_max = 0;
  longint e_sed = 0;

  function automatic int apx_f(int a, int b);
    int lo, mid, hi;
    lo  = 3;
    mid = ((a | b) >> 2) & 3;
    hi  = ((a >> 4) & 15) + ((b >> 4) & 15) + ((a >> 3) & (b >> 3) & 1);
    return hi * 16 + mid * 4 + lo;
  endfunction

  function automatic int ed_f(int a, int b);
    int d;
    d = apx_f(a, b) - (a + b);
    return (d < 0) ? -d : d;
  endfunction

  // Metrics over the first lim pairs of the sweep order.
  task automatic model(input int al, input int ah, input int bl, input int bh, input int lim,
                       output int np, output int ne, output longint s, output int mx);
    int d;
    np = 0; ne = 0; s = 0; mx = 0;
    for (int a = al; a <= ah; a++) begin
      for (int b = bl; b <= bh; b++) begin
        if (np < lim) begin
          d = ed_f(a, b);
          np++;
          if (d != 0) ne++;
          s += d;
          if (d > mx) mx = d;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model expectation of the current sweep.
  always @(negedge clk) begin
    if (rst_n && mode == 1) begin
      chk("busy", busy, (cyc >= s_edge && cyc < d_edge) ? 1 : 0);
      chk("done", done, (cyc == d_edge) ? 1 : 0);
      if (cyc == s_edge) begin
        chk("clr_pairs", pair_cnt, 0);
        chk("clr_err", err_cnt, 0);
        chk("clr_sed", sed, 0);
        chk("clr_max", max_ed, 0);
      end
      if (cyc >= d_edge) begin
        chk("pair_cnt", pair_cnt, e_pairs);
        chk("err_cnt", err_cnt, e_err);
        chk("sed", sed, e_sed);
        chk("max_ed", max_ed, e_max);
        chk("bad_range", bad_range, 0);
      end
    end else if (rst_n && mode == 2) begin
      chk("bad_busy", busy, 0);
      chk("bad_done", done, (cyc == d_edge) ? 1 : 0);
      if (cyc >= d_edge) begin
        chk("bad_flag", bad_range, 1);
        chk("bad_pairs", pair_cnt, 0);
        chk("bad_err", err_cnt, 0);
        chk("bad_sed", sed, 0);
        chk("bad_max", max_ed, 0);
      end
    end else if (rst_n && mode == 3) begin
      chk("abort_busy", busy, (cyc >= s_edge && cyc < d_edge) ? 1 : 0);
      chk("abort_done", done, 0);
    end
  end

  task automatic go(input int al, input int ah, input int bl, input int bh,
                    input int st_off, input int st_len);
    int np, ne, mx;
    longint s;
    @(posedge clk); #1;
    a_lo = 8'(al); a_hi = 8'(ah); b_lo = 8'(bl); b_hi = 8'(bh);
    start  = 1'b1;
    s_edge = cyc + 1;
    if (al > ah || bl > bh) begin
      e_pairs = 0; e_err = 0; e_sed = 0; e_max = 0;
      d_edge  = s_edge;
      mode    = 2;
    end else begin
      model(al, ah, bl, bh, BIG, np, ne, s, mx);
      e_pairs = np; e_err = ne; e_sed = s; e_max = mx;
      d_edge  = s_edge + np + 3 + st_len;
      mode    = 1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the bound inputs: the sweep must run from latched copies.
    a_lo = 8'hA5; a_hi = 8'h5A; b_lo = 8'hA5; b_hi = 8'h5A;
    if (st_len > 0) begin
      repeat (st_off) @(posedge clk);
      #1 stall = 1'b1;
      repeat (st_len) @(posedge clk);
      #1 stall = 1'b0;
    end
    while (cyc < d_edge + 2) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #3_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int np, ne, mx, pc;
    longint s;

    // Outputs while held in reset
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bad", bad_range, 0);
    chk("rst_pairs", pair_cnt, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_sed", sed, 0);
    chk("rst_max", max_ed, 0);
    @(negedge clk); rst_n = 1'b1;

    // Hand-computed pins on the model itself
    chk("pin_apx_8_8", apx_f(8, 8), 27);
    model(0, 0, 0, 0, BIG, np, ne, s, mx);
    chk("pin1_pairs", np, 1); chk("pin1_err", ne, 1); chk("pin1_sed", s, 3); chk("pin1_max", mx, 3);
    model(0, 0, 0, 3, BIG, np, ne, s, mx);
    chk("pin4_pairs", np, 4); chk("pin4_err", ne, 3); chk("pin4_sed", s, 6); chk("pin4_max", mx, 3);
    model(8, 8, 8, 8, BIG, np, ne, s, mx);
    chk("pin8_sed", s, 11); chk("pin8_max", mx, 11);

    // Directed sweeps
    go(0, 0, 0, 0, 0, 0);
    chk("lat_single", d_edge - s_edge, 4);
    go(0, 0, 0, 3, 0, 0);
    chk("lat_row", d_edge - s_edge, 7);
    go(8, 8, 8, 8, 0, 0);
    go(5, 4, 0, 0, 0, 0);
    go(0, 3, 7, 6, 0, 0);
    go(254, 255, 250, 255, 0, 0);
    go(3, 5, 10, 13, 2, 3);

    // Abort a full sweep on edge 100 after the start edge
    @(posedge clk); #1;
    a_lo = 8'd0; a_hi = 8'd255; b_lo = 8'd0; b_hi = 8'd255;
    start  = 1'b1;
    s_edge = cyc + 1;
    d_edge = s_edge + 100;
    mode   = 3;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < d_edge - 1) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    pc = int'(pair_cnt);
    chk("abort_le100", (pc <= 100) ? 1 : 0, 1);
    chk("abort_ge90", (pc >= 90) ? 1 : 0, 1);
    model(0, 255, 0, 255, pc, np, ne, s, mx);
    chk("abort_err", err_cnt, ne);
    chk("abort_sed", sed, s);
    chk("abort_max", max_ed, mx);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_frozen", pair_cnt, pc);
    go(1, 2, 8, 9, 0, 0);

    // Reset in the middle of a sweep
    mode = 0;
    @(posedge clk); #1;
    a_lo = 8'd0; a_hi = 8'd255; b_lo = 8'd0; b_hi = 8'd255;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    chk("mid_progress", (pair_cnt > 17'd0) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_bad", bad_range, 0);
    chk("mrst_pairs", pair_cnt, 0);
    chk("mrst_err", err_cnt, 0);
    chk("mrst_sed", sed, 0);
    chk("mrst_max", max_ed, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", busy, 0);

    // Full sweep with a 10-cycle stall mid-run
    go(0, 255, 0, 255, 1000, 10);
    chk("lat_full", d_edge - s_edge, 65549);
    chk("full_pairs_model", e_pairs, 65536);
    chk("sed_no_sat", (e_sed < 64'h0000_0000_FFFF_FFFF) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hoeraa_err_sweep.md
Name: hoeraa_err_sweep

Overview:
- Self-contained error-characterisation controller for the 8-bit HOERAA approximate adder.
- Sweeps a programmable rectangle of operand pairs through an internal HOERAA instance and an exact 8-bit adder, one pair per cycle, in a 3-stage pipeline.
- Accumulates error metrics: error count, sum of error distances, maximum error distance, and pair count.
- Used by the characterisation bench and the on-FPGA metric harness in place of software sweeps.

Parameters:
- ACC_W, 32: width of the sum-of-error-distance accumulator; saturates at 2^ACC_W-1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a sweep; accepted only in IDLE
- abort  in  1  cancel a running sweep
- stall  in  1  freeze sweep and pipeline for this cycle
- a_lo, a_hi  in  8 each  outer-loop operand A bounds, inclusive
- b_lo, b_hi  in  8 each  inner-loop operand B bounds, inclusive
- busy  out  1  sweep in progress (RUN or DRAIN)
- done  out  1  one-cycle pulse when metrics are final
- bad_range  out  1  set with done when a_lo>a_hi or b_lo>b_hi
- pair_cnt  out  17  pairs evaluated
- err_cnt  out  17  pairs with approx != exact
- sed  out  ACC_W  sum of |approx - exact|
- max_ed  out  9  largest |approx - exact|

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0; counters and pipeline valids cleared. This also applies to a reset mid-sweep.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on start=1:
  - Latch all four bounds.
  - Clear pair_cnt, err_cnt, sed, max_ed and bad_range.
  - busy=1 from the next cycle.
- IDLE with start=1 and bad bounds:
  - Stay IDLE; busy stays 0.
  - Next cycle: done=1 and bad_range=1, with all metrics 0.
- Sweep order in RUN: A from a_lo to a_hi (outer), B from b_lo to b_hi (inner, wraps to b_lo when A increments). One pair per non-stalled cycle.
- RUN -> DRAIN after the pair (a_hi, b_hi) is issued.
- DRAIN -> IDLE when the pipeline is empty.
- Pipeline stages:
  - S0: registered operands plus valid.
  - S1: registered approx (9b) and exact (9b) sums.
  - S2: ED = |approx - exact|, computed at 9-bit width, is accumulated.
- Accumulation on each valid S2 pair:
  - pair_cnt += 1.
  - err_cnt += (ED != 0).
  - sed += ED, saturating.
  - max_ed = max(max_ed, ED).
- Latency, with N = (a_hi-a_lo+1)*(b_hi-b_lo+1):
  - done pulses on edge N+3 after the start-accept edge (start sampled at edge 0), plus one edge for every stall cycle.
  - busy falls on that same edge.
- Metric stability: metrics are final and stable from done until the next accepted start.
- stall=1: no counter, pipeline register or accumulator changes. State is held; abort still wins over stall.
- abort=1 in RUN/DRAIN:
  - Next state is IDLE; pipeline valids are cleared.
  - busy=0 and no done pulse.
  - Metrics hold their partial values.
- start while busy: ignored.
- start and abort in the same IDLE cycle: start is taken; abort is ignored in IDLE.
- Bound counters are 8 bits. Terminal detection compares against a_hi/b_hi and never relies on overflow, so a_hi=255 or b_hi=255 terminates correctly.
- HOERAA model, for reference in checking:
  - sum[1:0] = 2'b11.
  - sum[3:2] = a[3:2] | b[3:2].
  - Upper part: {sum[8], sum[7:4]} = a[7:4] + b[7:4] + (a[3] & b[3]).

Test Plan:
- Single pair (0,0): a_lo=a_hi=b_lo=b_hi=0, start -> done on edge 4 (N+3 = 4), busy=0 after; pair_cnt=1, err_cnt=1, sed=3, max_ed=3.
- Small row: A=0, B 0..3 -> pair_cnt=4, err_cnt=3, sed=6, max_ed=3; done on edge 7.
- Carry-in case: a_lo=a_hi=8, b_lo=b_hi=8 -> approx=27, exact=16; pair_cnt=1, err_cnt=1, sed=11, max_ed=11.
- Full sweep 0..255 x 0..255 -> pair_cnt=65536; done on edge 65539.
  - With stall held for 10 cycles mid-run: done on edge 65549.
  - Results must match a scoreboard model; sed must not saturate at ACC_W=32.
- Bad range: a_lo=5, a_hi=4, start -> next cycle done=1, bad_range=1, all metrics 0, busy never 1.
- Abort and reset:
  - Full-sweep start, abort at cycle 100 -> busy=0 next cycle, no done, pair_cnt<=100 and frozen; a new start clears metrics.
  - rst_n pulsed low mid-sweep -> all outputs 0 immediately.
